// File: rtl/lzc_pattern_gen.sv
// Stimulus generator for leading-zero counters: emits vectors with an exactly
// controlled leading-zero count (sweep or LFSR-random) over a valid/ready port.
module lzc_pattern_gen #(
    parameter int          WIDTH    = 16,
    parameter logic [31:0] SEED     = 32'h0000_0001,
    parameter int          NUM_RAND = 64,
    localparam int         ZW       = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] A,
    output logic [ZW-1:0]    zeros,
    output logic             busy,
    output logic             done
);
    localparam int          MAXN       = (WIDTH + 1 > NUM_RAND) ? WIDTH + 1 : NUM_RAND;
    localparam int          CW         = $clog2(MAXN) + 1;
    localparam logic [31:0] SEED_INIT  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] TAPS       = 32'h8020_0003;
    localparam logic [ZW-1:0] KMAX     = ZW'(WIDTH);
    localparam logic [ZW-1:0] KWRAP    = ZW'(WIDTH + 1);
    localparam logic [CW-1:0] LAST_SWP = CW'(WIDTH);
    localparam logic [CW-1:0] LAST_RND = CW'(NUM_RAND - 1);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [ZW-1:0]    zeros_q, zeros_d;
    logic             valid_q, valid_d;

    logic [31:0]      lfsr_nx;
    logic [CW-1:0]    cnt_inc;
    logic             gen_mode;
    logic             last_vec;
    logic [ZW-1:0]    k_next;

    // Fold out-of-range raw counts back into 0..WIDTH.
    function automatic logic [ZW-1:0] rand_k(input logic [ZW-1:0] kr);
        return (kr > KMAX) ? kr - KWRAP : kr;
    endfunction

    function automatic logic [WIDTH-1:0] form_vec(input logic [ZW-1:0] k,
                                                  input logic [WIDTH-2:0] r);
        logic [WIDTH-1:0] base;
        base = {1'b1, r};
        if (k >= KMAX) begin
            return '0;
        end
        return base >> k;
    endfunction

    assign lfsr_nx  = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    assign cnt_inc  = cnt_q + CW'(1);
    assign gen_mode = (state_q == S_IDLE) ? mode : mode_q;
    assign last_vec = mode_q ? (cnt_q == LAST_RND) : (cnt_q == LAST_SWP);

    // Count for the vector built on this edge; the first sweep vector is always k=0.
    always_comb begin
        k_next = rand_k(lfsr_nx[31 -: ZW]);
        if (!gen_mode) begin
            k_next = (state_q == S_IDLE) ? '0 : cnt_inc[ZW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        zeros_d = zeros_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EMIT;
                    mode_d  = mode;
                    cnt_d   = '0;
                    lfsr_d  = lfsr_nx;
                    a_d     = form_vec(k_next, lfsr_nx[WIDTH-2:0]);
                    zeros_d = k_next;
                    valid_d = 1'b1;
                end
            end
            S_EMIT: begin
                if (valid_q && out_ready) begin
                    if (last_vec) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_inc;
                        lfsr_d  = lfsr_nx;
                        a_d     = form_vec(k_next, lfsr_nx[WIDTH-2:0]);
                        zeros_d = k_next;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            lfsr_q  <= SEED_INIT;
            cnt_q   <= '0;
            a_q     <= '0;
            zeros_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            zeros_q <= zeros_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign A         = a_q;
    assign zeros     = zeros_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
endmodule

// File: doc/lzc_pattern_gen.md
# lzc_pattern_gen

Self-checking stimulus generator for the leading-zero-counter family. Produces vectors `A` with a known, exactly controlled number of leading zeros, together with the expected count `zeros`. It is the writing side of the LZC check: the output drives any LZC instance's `A` input, and `zeros` is compared against that instance's `{~V, Z}` result. It runs in sweep mode (every count 0..WIDTH) or random mode (LFSR-chosen counts), with a valid/ready output handshake.

## Interface
- `WIDTH`, default 16: vector width. Legal values are 4, 8, 16 and 32.
- `SEED`, default 32'h0000_0001: initial 32-bit LFSR state. A value of 0 is replaced by 1.
- `NUM_RAND`, default 64: number of vectors per random-mode run. Must be ≥ 1.
- Derived `ZW = $clog2(WIDTH)+1`.
- `clk`  in  1  clock. Everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run. Sampled only in IDLE.
- `mode`  in  1  0 = sweep, 1 = random. Sampled together with `start`.
- `out_ready`  in  1  consumer accepts the current vector.
- `out_valid`  out  1  `A` and `zeros` are valid.
- `A`  out  WIDTH  generated vector.
- `zeros`  out  ZW  exact number of leading zeros in `A` (range 0..WIDTH).
- `busy`  out  1  a run is in progress.
- `done`  out  1  one-cycle pulse after the last vector is accepted.

## Operation
- **LFSR**: 32-bit Galois, right-shifting. One step is `lfsr = lfsr[0] ? (lfsr>>1) ^ 32'h80200003 : lfsr>>1`.
  - It steps exactly once per generated vector, before that vector is formed.
  - It is never all-zero.
  - It holds its state across runs. Only `rst` reloads `SEED`.
- **Vector formation** from count `k` and `r = lfsr[WIDTH-1:0]` (post-step):
  - If `k < WIDTH`: `A = {1'b1, r[WIDTH-2:0]} >> k`.
  - If `k == WIDTH`: `A = 0`.
  - In both cases `zeros = k`.
- **Sweep mode**:
  - `k` runs 0, 1, …, WIDTH in order.
  - A run is WIDTH+1 vectors.
- **Random mode**:
  - `k_raw = lfsr[31 -: ZW]` (post-step).
  - `k = (k_raw > WIDTH) ? k_raw - (WIDTH+1) : k_raw`.
  - A run is NUM_RAND vectors.
- **FSM** states are IDLE, EMIT and DONE.
  - IDLE → EMIT: on `start`. Latch `mode`, clear the vector counter, step the LFSR, and register the first vector with `out_valid=1`.
  - EMIT, no handshake (`out_valid & ~out_ready`): hold `A`, `zeros` and the LFSR unchanged.
  - EMIT, handshake on a non-last vector: step the LFSR and register the next vector in the same edge. `out_valid` stays 1, so vectors go back-to-back.
  - EMIT, handshake on the last vector: → DONE, with `out_valid=0`.
  - DONE → IDLE: unconditionally, with `done=1` for that single cycle.
- **Output behaviour by state**:
  - `busy` = 1 in EMIT and DONE, 0 in IDLE.
  - `start` is ignored while `busy` is 1.
  - `mode` changes during a run have no effect.
- **Vector counter**:
  - Width is `$clog2(max(WIDTH+1, NUM_RAND))+1`.
  - It increments on each handshake.
  - "Last vector" means counter == total−1.

## Timing
- **Reset values**:
  - Outputs: `out_valid`, `A`, `zeros`, `busy` and `done` are all 0.
  - Internal state: FSM = IDLE, LFSR = SEED (or 1 if SEED is 0), counter = 0.
- **Latency**: `start` sampled at edge t gives `out_valid=1` after edge t.
- **Throughput**: with `out_ready` held high, one vector per cycle.
  - A sweep run therefore shows `out_valid` for WIDTH+1 consecutive cycles.
  - `done` follows one cycle later, and `busy` drops one cycle after `done`.
- **Handshake hold**: `A` and `zeros` are registered outputs. They must not change while `out_valid & ~out_ready`.
- **Reset mid-run**: `rst` asserted in any state returns every output and all internal state to the reset values at that edge. No `done` pulse is generated.
- **`start` with `rst`**: if both are asserted in the same cycle, `rst` wins.

## Test plan
- **Reset**: WIDTH=16, SEED=1, assert `rst` for 2 cycles → all outputs 0 and `busy=0`. `start` held with `rst` → still IDLE.
- **Sweep with `out_ready` = 1**: expect 17 back-to-back vectors.
  - Vector 0: `A=16'h8003`, `zeros=0`.
  - Vector 1: `A=16'h4001`, `zeros=1`.
  - Vector 16: `A=16'h0000`, `zeros=16`.
  - `done` pulses the cycle after the last handshake.
  - Every vector satisfies the leading-zero count == `zeros`.
- **Backpressure**: hold `out_ready=0` for 5 cycles on vector 3 → `A` and `zeros` stay stable, `busy=1`, nothing is skipped or duplicated. Release → vector 4 follows.
- **Random run**: `mode=1`, NUM_RAND=64, random `out_ready` → exactly 64 handshakes.
  - Every `zeros` is in 0..16 and matches a bit-exact software model of the LFSR and formation rules.
  - `start` pulses during the run are ignored.
- **Reset mid-run**: assert `rst` after the 7th handshake → IDLE next edge, no `done`. A fresh sweep then reproduces the Sweep scenario's vector 0 (`16'h8003`).
- **Width 32**: WIDTH=32 sweep → 33 vectors, `zeros` 0..32. Compare against all LZC variants instantiated at 32 bits: no mismatches.
